approx_add_issue: RTL and testbench
===================================

# approx_add_issue

Two-stage valid/ready issue and retire pipeline around the 32-bit approximate Sklansky adder in the approximate-CPU datapath.
- Stage S1 registers the operands and drives the adder's `a`, `b`, `ci`, `size_enable` and `approx_level` inputs.
- Stage S2 captures the adder's `s` and `co`.
- The block converts an operation width into a `size_enable` mask and applies a software-set approximation level.
- Level changes take effect only at a drained pipeline, so every result in flight uses one consistent level.

## Interface
Parameters:
- CNT_W, 16, width of the saturating approximate-operation counter

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- cfg_we  in  1  write request for approximation level
- cfg_level  in  3  new approximation level (0 = exact)
- cfg_busy  out  1  write pending, not yet applied
- active_level  out  3  level currently applied to new operations
- in_valid / in_ready  in / out  1 / 1  operation handshake
- in_a, in_b  in  32  operands
- in_ci  in  1  carry-in
- in_size  in  2  operation width: 00 byte, 01 half, 10 word, 11 treated as word
- in_exact  in  1  force level 0 for this operation only
- add_a, add_b  out  32  to adder, registered, masked
- add_ci  out  1  to adder
- add_size_enable  out  32  to adder
- add_approx_level  out  3  to adder
- add_s  in  32  sum from adder (combinational from add_* outputs)
- add_co  in  1  carry-out from adder
- out_valid / out_ready  out / in  1 / 1  result handshake
- out_sum  out  32  registered sum
- out_co  out  1  registered carry-out (word only)
- out_approx  out  1  result was produced with level ≠ 0
- approx_cnt  out  CNT_W  saturating count of retired approximate results

## Operation
- **Mask:** byte → 0x0000_00FF, half → 0x0000_FFFF, word/11 → 0xFFFF_FFFF.
  - `add_size_enable` = mask; `add_a` = in_a & mask; `add_b` = in_b & mask.
  - `add_ci` = in_ci for all sizes.
- **S1 level:** S1 latches `add_approx_level` = in_exact ? 0 : active_level.
- **S2 capture:** `out_sum` = add_s; `out_co` = add_co if S1 size is word, else 0; `out_approx` = (S1 level ≠ 0).
- **Counter:** `approx_cnt` increments on each out handshake with out_approx = 1 and holds at 2^CNT_W−1.
- **Config FSM, states RUN / DRAIN:**
  - In RUN, cfg_we = 1 latches cfg_level into a pending register, sets cfg_busy and enters DRAIN.
  - In DRAIN, in_ready = 0. When S1 and S2 are both empty, the pending value goes to active_level, cfg_busy clears, and the FSM returns to RUN the next cycle.
  - cfg_we while in DRAIN overwrites the pending value; last write wins.
  - cfg_we in the same cycle as an in handshake: the operation is accepted at the old level, then DRAIN begins.
- **Flow control:**
  - S1 advances when S2 is empty or out_ready = 1.
  - in_ready = RUN && (!s1_valid || s1_advance).
  - No bubbles at full rate.
- Payload outputs are unconstrained while their valid is low; they hold the last value.

## Timing
- **Reset values:** all outputs 0, except in_ready = 1 and add_size_enable = 0. active_level = 0, FSM in RUN.
- **Latency:** an operation accepted at edge N drives add_* from N+1. out_valid rises after edge N+2.
- **Throughput:** 1 operation per cycle with out_ready held high.
- **Adder path:** the add_* → add_s path is one combinational cycle between S1 and S2.
- **Stall:** out_ready = 0 with S2 full holds S2 and S1 stable and drops in_ready if S1 is full. out_sum must not change while out_valid && !out_ready.
- **Config latency:** the minimum delay from cfg_we to active_level update is 1 cycle on an empty pipeline. Otherwise it is the drain time plus 1.
- **Reset mid-operation:** asynchronous clear of both stages, the pending config and the counter. No result is emitted for squashed operations.

## Test plan
- **Word add, exact:** after reset, a = 0xFFFF_FFFF, b = 0x1, ci = 0, size 10 → out_sum 0x0, out_co 1, out_approx 0, out_valid two edges after accept; add_size_enable = 0xFFFF_FFFF.
- **Byte masking:** a = 0x1234_56F0, b = 0x0000_0020, size 00 → add_a 0xF0, add_b 0x20, add_size_enable 0xFF, out_co 0; out_sum matches adder's sum for masked inputs.
- **Config drain:** with 2 operations in flight, cfg_we with level 3 → cfg_busy 1, in_ready 0 until both retire, active_level = 3 one cycle after drain, then in_ready 1. The next operation shows add_approx_level 3 and out_approx 1; in_exact = 1 gives level 0.
- **Backpressure:** 4 back-to-back operations with out_ready low for 3 cycles → S2 value stable, in_ready low once S1 fills, all 4 results retired in order with none lost or duplicated.
- **Counter saturation:** CNT_W = 2, level 1, 5 approximate operations retired → approx_cnt 1, 2, 3, 3, 3.
- **Async reset mid-stream:** rst asserted between clock edges with S1 and S2 full and a config pending → all outputs at reset values immediately, active_level 0, no out_valid after release until a new accept.

Source files
------------

// File: rtl/approx_add_issue.sv
// approx_add_issue
//   Two-stage valid/ready issue/retire wrapper around the 32-bit approximate
//   Sklansky adder. S1 registers the masked operands and drives the adder,
//   S2 captures the adder's sum/carry. A small RUN/DRAIN FSM applies
//   software approximation-level changes only on an empty pipeline, so every
//   result in flight was computed at one consistent level.
//
// Ports
//   clk, rst                  clock, async active-high reset
//   cfg_we/cfg_level/cfg_busy approximation-level write and pending flag
//   active_level              level applied to newly accepted operations
//   in_*                      operation handshake + operands/size/exact
//   add_*                     registered adder inputs / adder results
//   out_*                     result handshake + sum/carry/approx flag
//   approx_cnt                saturating count of retired approximate results
module approx_add_issue #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_level,
  output logic             cfg_busy,
  output logic [2:0]       active_level,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_ci,
  input  logic [1:0]       in_size,
  input  logic             in_exact,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  output logic             add_ci,
  output logic [31:0]      add_size_enable,
  output logic [2:0]       add_approx_level,
  input  logic [31:0]      add_s,
  input  logic             add_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic             out_co,
  output logic             out_approx,
  output logic [CNT_W-1:0] approx_cnt
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t      state, state_nxt;
  logic        s1_valid, s2_valid, s1_word;
  logic        s1_advance, in_fire, out_fire, pipe_empty;
  logic [2:0]  pend_level;
  logic [31:0] mask;

  // Width mask; size 11 is treated as a full word.
  always_comb begin
    mask = 32'hFFFF_FFFF;
    case (in_size)
      2'b00:   mask = 32'h0000_00FF;
      2'b01:   mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
  end

  assign s1_advance = !s2_valid || out_ready;
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = s2_valid && out_ready;
  assign pipe_empty = !s1_valid && !s2_valid;
  assign out_valid  = s2_valid;

  // ---------------- config FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (cfg_we)     state_nxt = DRAIN;
      DRAIN:   if (pipe_empty) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // S1 may still accept when empty even if S2 is stalled.
  always_comb begin
    cfg_busy = (state == DRAIN);
    in_ready = (state == RUN) && (!s1_valid || s1_advance);
  end

  // A write landing in the same cycle the drain completes wins over the
  // older pending value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_level   <= 3'd0;
      active_level <= 3'd0;
    end else begin
      if (cfg_we) pend_level <= cfg_level;
      if (state == DRAIN && pipe_empty)
        active_level <= cfg_we ? cfg_level : pend_level;
    end
  end

  // ---------------- S1: operand issue ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid         <= 1'b0;
      s1_word          <= 1'b0;
      add_a            <= 32'd0;
      add_b            <= 32'd0;
      add_ci           <= 1'b0;
      add_size_enable  <= 32'd0;
      add_approx_level <= 3'd0;
    end else begin
      if (in_fire) begin
        s1_valid         <= 1'b1;
        s1_word          <= in_size[1];
        add_a            <= in_a & mask;
        add_b            <= in_b & mask;
        add_ci           <= in_ci;
        add_size_enable  <= mask;
        add_approx_level <= in_exact ? 3'd0 : active_level;
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // ---------------- S2: result capture ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      out_sum    <= 32'd0;
      out_co     <= 1'b0;
      out_approx <= 1'b0;
    end else begin
      if (s1_valid && s1_advance) begin
        s2_valid   <= 1'b1;
        out_sum    <= add_s;
        // Narrow ops report no carry; the adder's lane carry is not meaningful here.
        out_co     <= s1_word & add_co;
        out_approx <= (add_approx_level != 3'd0);
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  // ---------------- approximate-result counter ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) approx_cnt <= '0;
    else if (out_fire && out_approx && (approx_cnt != {CNT_W{1'b1}}))
      approx_cnt <= approx_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_approx_add_issue.sv
module tb_approx_add_issue;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [2:0]       cfg_level;
  logic             cfg_busy;
  logic [2:0]       active_level;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a, in_b;
  logic             in_ci;
  logic [1:0]       in_size;
  logic             in_exact;
  logic [31:0]      add_a, add_b;
  logic             add_ci;
  logic [31:0]      add_size_enable;
  logic [2:0]       add_approx_level;
  logic [31:0]      add_s;
  logic             add_co;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_sum;
  logic             out_co;
  logic             out_approx;
  logic [CNT_W-1:0] approx_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int acc, ret;

  always #5 clk = ~clk;

  approx_add_issue #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_level(cfg_level), .cfg_busy(cfg_busy),
    .active_level(active_level),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ci(in_ci), .in_size(in_size),
    .in_exact(in_exact),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_size_enable(add_size_enable), .add_approx_level(add_approx_level),
    .add_s(add_s), .add_co(add_co),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_co(out_co), .out_approx(out_approx),
    .approx_cnt(approx_cnt)
  );

  // Stand-in adder: exact sum within the enabled width, carry out of the
  // top enabled bit.
  logic [32:0] sum_w;
  logic [16:0] sum_h;
  logic [8:0]  sum_b;
  always_comb begin
    sum_w = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_ci};
    sum_h = {1'b0, add_a[15:0]} + {1'b0, add_b[15:0]} + {16'd0, add_ci};
    sum_b = {1'b0, add_a[7:0]} + {1'b0, add_b[7:0]} + {8'd0, add_ci};
    add_s  = sum_w[31:0];
    add_co = sum_w[32];
    if (add_size_enable == 32'h0000_00FF) begin
      add_s  = {24'd0, sum_b[7:0]};
      add_co = sum_b[8];
    end else if (add_size_enable == 32'h0000_FFFF) begin
      add_s  = {16'd0, sum_h[15:0]};
      add_co = sum_h[16];
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs;
    cfg_we = 0; cfg_level = 0; in_valid = 0; in_a = 0; in_b = 0;
    in_ci = 0; in_size = 0; in_exact = 0; out_ready = 1;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_reset;
    do_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got %0b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready got %0b want 1", in_ready); end
    n_checks++; if (add_size_enable !== 32'd0) begin n_fail++; $display("FAIL reset add_size_enable got %h want 0", add_size_enable); end
    n_checks++; if (active_level !== 3'd0) begin n_fail++; $display("FAIL reset active_level got %0d want 0", active_level); end
    n_checks++; if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL reset cfg_busy got %0b want 0", cfg_busy); end
    n_checks++; if (approx_cnt !== '0) begin n_fail++; $display("FAIL reset approx_cnt got %0d want 0", approx_cnt); end
  endtask

  task automatic test_word_exact;
    in_valid = 1; in_a = 32'hFFFF_FFFF; in_b = 32'h1; in_ci = 0; in_size = 2'b10;
    tick();
    in_valid = 0;
    n_checks++; if (add_a !== 32'hFFFF_FFFF || add_b !== 32'h1) begin n_fail++; $display("FAIL word add_a/add_b got %h/%h want ffffffff/00000001", add_a, add_b); end
    n_checks++; if (add_size_enable !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL word add_size_enable got %h want ffffffff", add_size_enable); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL word early out_valid got %0b want 0", out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL word out_valid got %0b want 1", out_valid); end
    n_checks++; if (out_sum !== 32'h0 || out_co !== 1'b1 || out_approx !== 1'b0) begin n_fail++; $display("FAIL word result got sum=%h co=%0b ap=%0b want 0/1/0", out_sum, out_co, out_approx); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL word out_valid after retire got %0b want 0", out_valid); end
  endtask

  task automatic test_byte_mask;
    in_valid = 1; in_a = 32'h1234_56F0; in_b = 32'h0000_0020; in_size = 2'b00;
    tick();
    in_valid = 0;
    n_checks++; if (add_a !== 32'hF0 || add_b !== 32'h20) begin n_fail++; $display("FAIL byte add_a/add_b got %h/%h want f0/20", add_a, add_b); end
    n_checks++; if (add_size_enable !== 32'hFF) begin n_fail++; $display("FAIL byte add_size_enable got %h want ff", add_size_enable); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_sum !== 32'h10 || out_co !== 1'b0) begin n_fail++; $display("FAIL byte result got v=%0b sum=%h co=%0b want 1/10/0", out_valid, out_sum, out_co); end
    tick();
  endtask

  task automatic test_config_drain;
    int cnt0;
    out_ready = 1;
    in_valid = 1; in_a = 1; in_b = 2; in_size = 2'b10;
    tick();
    in_a = 3; in_b = 4;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_sum !== 32'd3) begin n_fail++; $display("FAIL drain op1 got v=%0b sum=%h want 1/3", out_valid, out_sum); end
    in_valid = 0; cfg_we = 1; cfg_level = 3;
    tick();
    cfg_we = 0;
    n_checks++; if (cfg_busy !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL drain start got busy=%0b in_ready=%0b want 1/0", cfg_busy, in_ready); end
    n_checks++; if (active_level !== 3'd0 || out_sum !== 32'd7) begin n_fail++; $display("FAIL drain op2 got lvl=%0d sum=%h want 0/7", active_level, out_sum); end
    in_valid = 1; in_a = 10; in_b = 5;   // must wait out the drain
    tick();
    n_checks++; if (cfg_busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL drain empty got busy=%0b in_ready=%0b v=%0b want 1/0/0", cfg_busy, in_ready, out_valid); end
    tick();
    n_checks++; if (active_level !== 3'd3 || cfg_busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL drain apply got lvl=%0d busy=%0b in_ready=%0b want 3/0/1", active_level, cfg_busy, in_ready); end
    cnt0 = int'(approx_cnt);
    tick();
    n_checks++; if (add_approx_level !== 3'd3 || add_a !== 32'd10) begin n_fail++; $display("FAIL new level got lvl=%0d a=%h want 3/a", add_approx_level, add_a); end
    in_a = 1; in_b = 1; in_exact = 1;
    tick();
    in_valid = 0; in_exact = 0;
    n_checks++; if (out_valid !== 1'b1 || out_sum !== 32'd15 || out_approx !== 1'b1) begin n_fail++; $display("FAIL approx op got v=%0b sum=%h ap=%0b want 1/f/1", out_valid, out_sum, out_approx); end
    n_checks++; if (add_approx_level !== 3'd0) begin n_fail++; $display("FAIL exact op level got %0d want 0", add_approx_level); end
    tick();
    n_checks++; if (out_sum !== 32'd2 || out_approx !== 1'b0 || int'(approx_cnt) != cnt0 + 1) begin n_fail++; $display("FAIL exact op got sum=%h ap=%0b cnt=%0d want 2/0/%0d", out_sum, out_approx, approx_cnt, cnt0 + 1); end
    tick();
  endtask

  task automatic test_backpressure;
    logic [31:0] op_a [4];
    logic [31:0] op_b [4];
    logic [1:0]  op_sz [4];
    logic [31:0] exp_sum [4];
    logic        exp_co [4];
    logic        an, rn;
    op_a = '{32'h100, 32'h200, 32'hFFFF_FFFF, 32'h80};
    op_b = '{32'h1, 32'h2, 32'hFFFF_FFFF, 32'h80};
    op_sz = '{2'b10, 2'b10, 2'b10, 2'b00};
    exp_sum = '{32'h101, 32'h202, 32'hFFFF_FFFE, 32'h0};
    exp_co = '{1'b0, 1'b0, 1'b1, 1'b0};
    acc = 0; ret = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid = (acc < 4);
      in_a = op_a[acc % 4]; in_b = op_b[acc % 4]; in_size = op_sz[acc % 4];
      out_ready = (cyc >= 5);
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== exp_sum[0]) begin n_fail++; $display("FAIL stall cyc%0d got in_ready=%0b v=%0b sum=%h want 0/1/%h", cyc, in_ready, out_valid, out_sum, exp_sum[0]); end
      end
      an = in_valid && in_ready;
      rn = out_valid && out_ready;
      if (rn) begin
        n_checks++;
        if (ret >= 4) begin n_fail++; $display("FAIL bp extra result sum=%h want none", out_sum); end
        else if (out_sum !== exp_sum[ret] || out_co !== exp_co[ret] || out_approx !== 1'b1) begin
          n_fail++; $display("FAIL bp result%0d got sum=%h co=%0b ap=%0b want %h/%0b/1", ret, out_sum, out_co, out_approx, exp_sum[ret], exp_co[ret]);
        end
        ret++;
      end
      #(3);
      @(posedge clk); #1;
      if (an) acc++;
    end
    in_valid = 0; out_ready = 1;
    n_checks++; if (ret != 4 || acc != 4) begin n_fail++; $display("FAIL bp counts got ret=%0d acc=%0d want 4/4", ret, acc); end
  endtask

  task automatic test_counter_sat;
    logic an, rn;
    do_reset();
    cfg_we = 1; cfg_level = 1;
    tick();
    cfg_we = 0;
    n_checks++; if (cfg_busy !== 1'b1) begin n_fail++; $display("FAIL sat cfg_busy got %0b want 1", cfg_busy); end
    tick();
    n_checks++; if (active_level !== 3'd1 || cfg_busy !== 1'b0) begin n_fail++; $display("FAIL sat empty-pipe apply got lvl=%0d busy=%0b want 1/0", active_level, cfg_busy); end
    acc = 0; ret = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      in_valid = (acc < 5); in_a = acc; in_b = 1; in_size = 2'b10;
      #1;
      an = in_valid && in_ready;
      rn = out_valid && out_ready;
      tick();
      if (an) acc++;
      if (rn) begin
        ret++;
        n_checks++; if (int'(approx_cnt) != ((ret > 3) ? 3 : ret)) begin n_fail++; $display("FAIL sat cnt after %0d got %0d want %0d", ret, approx_cnt, (ret > 3) ? 3 : ret); end
      end
    end
    in_valid = 0;
    n_checks++; if (ret != 5) begin n_fail++; $display("FAIL sat retired got %0d want 5", ret); end
  endtask

  task automatic test_async_reset;
    out_ready = 0;
    in_valid = 1; in_a = 5; in_b = 6; in_size = 2'b10;
    tick();
    in_a = 7;
    tick();
    in_valid = 0; cfg_we = 1; cfg_level = 5;
    tick();
    cfg_we = 0;
    n_checks++; if (cfg_busy !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL ar setup got busy=%0b v=%0b want 1/1", cfg_busy, out_valid); end
    #2 rst = 1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || cfg_busy !== 1'b0) begin n_fail++; $display("FAIL ar flags got v=%0b in_ready=%0b busy=%0b want 0/1/0", out_valid, in_ready, cfg_busy); end
    n_checks++; if (active_level !== 3'd0 || approx_cnt !== '0 || add_size_enable !== 32'd0 || out_sum !== 32'd0 || add_a !== 32'd0) begin n_fail++; $display("FAIL ar values got lvl=%0d cnt=%0d se=%h sum=%h a=%h want all 0", active_level, approx_cnt, add_size_enable, out_sum, add_a); end
    @(negedge clk);
    rst = 0; out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0 || active_level !== 3'd0 || cfg_busy !== 1'b0) begin n_fail++; $display("FAIL ar post%0d got v=%0b lvl=%0d busy=%0b want 0/0/0", i, out_valid, active_level, cfg_busy); end
    end
    in_valid = 1; in_a = 2; in_b = 3;
    tick();
    in_valid = 0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar new op early got v=%0b want 0", out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_sum !== 32'd5 || out_approx !== 1'b0) begin n_fail++; $display("FAIL ar new op got v=%0b sum=%h ap=%0b want 1/5/0", out_valid, out_sum, out_approx); end
    tick();
  endtask

  initial begin
    test_reset();
    test_word_exact();
    test_byte_mask();
    test_config_drain();
    test_backpressure();
    test_counter_sat();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
